// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : imm_extend_pipe
//  Purpose  : Two-stage pipelined ARMv8 immediate extender with valid/ready
//             flow control, tag passthrough and illegal-format flagging.
//             Sits between decode and execute.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W   immediate output width (32 or 64)
//    TAG_W    width of the opaque tag carried with each request
//  Ports
//    Clk       in   rising-edge clock
//    Reset     in   synchronous active-high reset
//    InValid   in   upstream request present
//    InReady   out  request accepted this cycle (combinational from OutReady)
//    Imm26     in   instruction bits [25:0]
//    Ctrl      in   format select
//    OldVal    in   destination register value (MOVK only)
//    InTag     in   request tag
//    OutValid  out  BusImm / OutTag / Illegal valid
//    OutReady  in   downstream consumes result
//    BusImm    out  extended immediate
//    OutTag    out  result tag
//    Illegal   out  unsupported format or shift
//  Configuration macro
//    IMM_EXTEND_MOVK_EN  enables MOVK (Ctrl=101); otherwise Ctrl=101 is
//                        flagged illegal and OldVal is not registered.
// ============================================================================
module imm_extend_pipe #(
   parameter int DATA_W = 64,
   parameter int TAG_W  = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              InValid,
   output logic              InReady,
   input  logic [25:0]       Imm26,
   input  logic [2:0]        Ctrl,
   input  logic [DATA_W-1:0] OldVal,
   input  logic [TAG_W-1:0]  InTag,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [DATA_W-1:0] BusImm,
   output logic [TAG_W-1:0]  OutTag,
   output logic              Illegal
);

   localparam logic [2:0] C_ITYPE = 3'b000;
   localparam logic [2:0] C_DTYPE = 3'b001;
   localparam logic [2:0] C_BTYPE = 3'b010;
   localparam logic [2:0] C_CBZ   = 3'b011;
   localparam logic [2:0] C_MOVZ  = 3'b100;
   localparam logic [2:0] C_MOVK  = 3'b101;
   localparam logic [2:0] C_MOVN  = 3'b110;

   // ---------------------------------------------------------------- control
   logic s1_valid;
   logic s2_adv;
   logic s1_adv;
   logic accept;

   assign s2_adv  = !OutValid || OutReady;
   assign s1_adv  = s1_valid && s2_adv;
   assign InReady = !s1_valid || s2_adv;
   assign accept  = InValid && InReady;

   // ---------------------------------------------------------------- stage 1
   logic [25:0]      s1_imm;
   logic [2:0]       s1_ctrl;
   logic [TAG_W-1:0] s1_tag;

   // Payload needs no reset: it is only consumed while s1_valid is set.
   always_ff @(posedge Clk) begin
      if (accept) begin
         s1_imm  <= Imm26;
         s1_ctrl <= Ctrl;
         s1_tag  <= InTag;
      end
   end

`ifdef IMM_EXTEND_MOVK_EN
   logic [DATA_W-1:0] s1_old;

   always_ff @(posedge Clk) begin
      if (accept) begin
         s1_old <= OldVal;
      end
   end
`else
   // OldVal is intentionally ignored in this build.
   logic unused_old_val;
   assign unused_old_val = ^OldVal;
`endif

   // ---------------------------------------------------------------- decode
   logic [5:0]        shamt;
   logic [DATA_W-1:0] movz_val;
   logic              shift_bad;
   logic [DATA_W-1:0] dec_val;
   logic              dec_ill;

   // hw selects a 16-bit lane; shift amount is 16*hw.
   assign shamt     = {s1_imm[22:21], 4'b0000};
   assign movz_val  = {{(DATA_W-16){1'b0}}, s1_imm[20:5]} << shamt;
   // A 32-bit datapath has only lanes 0 and 1.
   assign shift_bad = (DATA_W == 32) && s1_imm[22];

`ifdef IMM_EXTEND_MOVK_EN
   logic [DATA_W-1:0] lane_mask;
   assign lane_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF} << shamt;
`endif

   always_comb begin
      dec_val = '0;
      dec_ill = 1'b0;
      case (s1_ctrl)
         C_ITYPE: dec_val = {{(DATA_W-12){1'b0}}, s1_imm[21:10]};
         C_DTYPE: dec_val = {{(DATA_W-9){s1_imm[20]}}, s1_imm[20:12]};
         C_BTYPE: dec_val = {{(DATA_W-28){s1_imm[25]}}, s1_imm[25:0], 2'b00};
         C_CBZ:   dec_val = {{(DATA_W-21){s1_imm[23]}}, s1_imm[23:5], 2'b00};
         C_MOVZ: begin
            dec_val = movz_val;
            dec_ill = shift_bad;
         end
         C_MOVN: begin
            dec_val = ~movz_val;
            dec_ill = shift_bad;
         end
`ifdef IMM_EXTEND_MOVK_EN
         C_MOVK: begin
            dec_val = (s1_old & ~lane_mask) | movz_val;
            dec_ill = shift_bad;
         end
`endif
         default: dec_ill = 1'b1;
      endcase
      // Illegal results always carry a zero immediate.
      if (dec_ill) begin
         dec_val = '0;
      end
   end

   // ---------------------------------------------------------------- stage 2
   always_ff @(posedge Clk) begin
      if (Reset) begin
         s1_valid <= 1'b0;
         OutValid <= 1'b0;
         BusImm   <= '0;
         OutTag   <= '0;
         Illegal  <= 1'b0;
      end else begin
         if (accept) begin
            s1_valid <= 1'b1;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end

         if (s2_adv) begin
            OutValid <= s1_valid;
         end

         if (s1_adv) begin
            BusImm  <= dec_val;
            OutTag  <= s1_tag;
            Illegal <= dec_ill;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_extend_pipe
//  Purpose  : Scoreboard bench for imm_extend_pipe. A 64-bit and a 32-bit
//             instance share one stimulus stream; expected results come from
//             an independent reference model and are queued on accept and
//             compared when each instance hands off a result.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imm_extend_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic [25:0] imm26;
   logic [2:0]  ctrl;
   logic [63:0] old_val;
   logic [7:0]  in_tag;

   logic        in_ready64, out_valid64, ill64;
   logic [63:0] bus64;
   logic [7:0]  tag64;
   logic        in_ready32, out_valid32, ill32;
   logic [31:0] bus32;
   logic [7:0]  tag32;

   int n_checks = 0;
   int n_errors = 0;
   int hs_count = 0;
   bit rnd_rdy  = 1'b0;

   always #5 clk = ~clk;

   imm_extend_pipe #(.DATA_W(64), .TAG_W(8)) u_dut64 (
      .Clk(clk), .Reset(reset), .InValid(in_valid), .InReady(in_ready64),
      .Imm26(imm26), .Ctrl(ctrl), .OldVal(old_val), .InTag(in_tag),
      .OutValid(out_valid64), .OutReady(out_ready), .BusImm(bus64),
      .OutTag(tag64), .Illegal(ill64)
   );

   imm_extend_pipe #(.DATA_W(32), .TAG_W(8)) u_dut32 (
      .Clk(clk), .Reset(reset), .InValid(in_valid), .InReady(in_ready32),
      .Imm26(imm26), .Ctrl(ctrl), .OldVal(old_val[31:0]), .InTag(in_tag),
      .OutValid(out_valid32), .OutReady(out_ready), .BusImm(bus32),
      .OutTag(tag32), .Illegal(ill32)
   );

   typedef struct {
      logic [63:0] val;
      logic        ill;
      logic [7:0]  tag;
   } exp_t;

   exp_t q64[$];
   exp_t q32[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model, written directly from the format table.
   function automatic logic [64:0] model(input logic [2:0] c, input logic [25:0] im,
                                         input logic [63:0] old, input bit w32);
      logic [63:0] v;
      logic        ill;
      logic [1:0]  hw;
      logic [15:0] i16;
      v   = '0;
      ill = 1'b0;
      hw  = im[22:21];
      i16 = im[20:5];
      case (c)
         3'd0: v = {52'b0, im[21:10]};
         3'd1: v = {{55{im[20]}}, im[20:12]};
         3'd2: v = {{36{im[25]}}, im, 2'b00};
         3'd3: v = {{43{im[23]}}, im[23:5], 2'b00};
         3'd4, 3'd6: begin
            v[16*hw +: 16] = i16;
            if (c == 3'd6) v = ~v;
            if (w32 && hw[1]) ill = 1'b1;
         end
         3'd5: begin
`ifdef IMM_EXTEND_MOVK_EN
            v = old;
            v[16*hw +: 16] = i16;
            if (w32 && hw[1]) ill = 1'b1;
`else
            ill = 1'b1;
`endif
         end
         default: ill = 1'b1;
      endcase
      if (w32) v[63:32] = '0;
      if (ill) v = '0;
      return {ill, v};
   endfunction

   function automatic logic [25:0] mov_imm(input logic [1:0] hw, input logic [15:0] v);
      return {3'b000, hw, v, 5'b00000};
   endfunction

   // Monitor: handshakes are sampled on the falling edge and take effect on
   // the following rising edge; inputs only change just after rising edges.
   logic        prev_stall = 1'b0;
   logic [63:0] held_bus;
   logic [7:0]  held_tag;
   logic        held_ill;

   always @(negedge clk) begin
      exp_t e;
      logic [64:0] m;
      if (reset) begin
         q64.delete();
         q32.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_bus", bus64, held_bus);
            check("hold_tag", {56'b0, tag64}, {56'b0, held_tag});
            check("hold_ill", {63'b0, ill64}, {63'b0, held_ill});
         end
         prev_stall = out_valid64 && !out_ready;
         held_bus   = bus64;
         held_tag   = tag64;
         held_ill   = ill64;

         if (out_valid64 && out_ready) begin
            hs_count++;
            if (q64.size() == 0) begin
               check("unexpected_out64", 64'd1, 64'd0);
            end else begin
               e = q64.pop_front();
               check("bus64", bus64, e.val);
               check("ill64", {63'b0, ill64}, {63'b0, e.ill});
               check("tag64", {56'b0, tag64}, {56'b0, e.tag});
            end
         end
         if (out_valid32 && out_ready) begin
            if (q32.size() == 0) begin
               check("unexpected_out32", 64'd1, 64'd0);
            end else begin
               e = q32.pop_front();
               check("bus32", {32'b0, bus32}, e.val);
               check("ill32", {63'b0, ill32}, {63'b0, e.ill});
               check("tag32", {56'b0, tag32}, {56'b0, e.tag});
            end
         end

         if (in_valid && in_ready64) begin
            m = model(ctrl, imm26, old_val, 1'b0);
            e.val = m[63:0]; e.ill = m[64]; e.tag = in_tag;
            q64.push_back(e);
         end
         if (in_valid && in_ready32) begin
            m = model(ctrl, imm26, old_val, 1'b1);
            e.val = m[63:0]; e.ill = m[64]; e.tag = in_tag;
            q32.push_back(e);
         end
      end
   end

   // Random downstream back-pressure during the random phase.
   always @(posedge clk) begin
      if (rnd_rdy) begin
         #1 out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Present one request; returns 1 ns after the accepting edge.
   task automatic send(input logic [2:0] c, input logic [25:0] im,
                       input logic [63:0] old, input logic [7:0] t);
      int n;
      in_valid = 1'b1;
      ctrl     = c;
      imm26    = im;
      old_val  = old;
      in_tag   = t;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready64 && n < 200);
      if (!in_ready64) check("accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int hs0;
      int n;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      imm26     = '0;
      ctrl      = '0;
      old_val   = '0;
      in_tag    = '0;
      repeat (3) tick();
      reset = 1'b0;

      // Reset state
      check("rst_out_valid", {63'b0, out_valid64}, 64'd0);
      check("rst_bus", bus64, 64'd0);
      check("rst_in_ready", {63'b0, in_ready64}, 64'd1);

      // I-type with exact two-cycle latency
      send(3'b000, 26'hFFF << 10, 64'd0, 8'h11);
      check("lat_c1_valid", {63'b0, out_valid64}, 64'd0);
      tick();
      check("lat_c2_valid", {63'b0, out_valid64}, 64'd1);

      // Format table directed cases
      send(3'b001, 26'h1FF << 12, 64'd0, 8'h12);
      send(3'b010, 26'h3FFFFFF, 64'd0, 8'h13);
      send(3'b011, 26'h1 << 5, 64'd0, 8'h14);
      send(3'b100, mov_imm(2'd3, 16'h1234), 64'd0, 8'h15);
      send(3'b110, mov_imm(2'd0, 16'h0001), 64'd0, 8'h16);
      send(3'b100, mov_imm(2'd2, 16'hBEEF), 64'd0, 8'h17);
      send(3'b110, mov_imm(2'd1, 16'h00F0), 64'd0, 8'h18);
      send(3'b101, mov_imm(2'd1, 16'h1234), 64'hAAAABBBBCCCCDDDD, 8'h19);
      send(3'b101, mov_imm(2'd3, 16'h5678), 64'hAAAABBBBCCCCDDDD, 8'h1A);
      send(3'b111, 26'h2AAAAAA, 64'd0, 8'h1B);
      repeat (4) tick();

      // Stall stream: both stages fill, InReady drops, outputs hold
      out_ready = 1'b0;
      send(3'b000, 26'h123 << 10, 64'd0, 8'd1);
      send(3'b010, 26'h0000100, 64'd0, 8'd2);
      check("stall_in_ready", {63'b0, in_ready64}, 64'd0);
      check("stall_out_valid", {63'b0, out_valid64}, 64'd1);
      check("stall_head_tag", {56'b0, tag64}, 64'd1);
      repeat (2) tick();
      out_ready = 1'b1;
      hs0 = hs_count;
      send(3'b100, mov_imm(2'd1, 16'hCAFE), 64'd0, 8'd3);
      send(3'b110, mov_imm(2'd2, 16'h8001), 64'd0, 8'd4);
      tick();
      tick();
      check("throughput", 64'(hs_count - hs0), 64'd4);

      // Mid-stream reset with both stages full
      out_ready = 1'b0;
      send(3'b001, 26'h0AB << 12, 64'd0, 8'h21);
      send(3'b011, 26'h7 << 5, 64'd0, 8'h22);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mrst_out_valid", {63'b0, out_valid64}, 64'd0);
      check("mrst_bus", bus64, 64'd0);
      check("mrst_tag", {56'b0, tag64}, 64'd0);
      check("mrst_ill", {63'b0, ill64}, 64'd0);
      check("mrst_in_ready", {63'b0, in_ready64}, 64'd1);
      out_ready = 1'b1;
      send(3'b000, 26'h3C0 << 10, 64'd0, 8'h23);
      check("mrst_c1_valid", {63'b0, out_valid64}, 64'd0);
      tick();
      check("mrst_c2_valid", {63'b0, out_valid64}, 64'd1);
      check("mrst_c2_tag", {56'b0, tag64}, 64'h23);

      // Random traffic with random back-pressure
      rnd_rdy = 1'b1;
      for (int i = 0; i < 60; i++) begin
         send(3'($urandom_range(0, 7)), 26'($urandom),
              {32'($urandom), 32'($urandom)}, 8'(8'h40 + i));
         if ($urandom_range(0, 3) == 0) tick();
      end
      rnd_rdy = 1'b0;
      #2;
      out_ready = 1'b1;

      // Drain
      n = 0;
      while ((q64.size() != 0 || q32.size() != 0) && n < 200) begin
         tick();
         n++;
      end
      check("drain_q64", 64'(q64.size()), 64'd0);
      check("drain_q32", 64'(q32.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Pipelined, parametrised successor to the single-cycle ARMv8 immediate extender.
- Takes the 26-bit instruction immediate field plus a 3-bit format control, and produces a DATA_W-bit immediate two cycles later.
- Adds valid/ready flow control, a tag passthrough, MOVN support, and illegal-format flagging.
- Sits between decode and execute in the pipelined datapath.

Parameters:
- DATA_W, 64: immediate output width; legal values are 32 and 64 only.
- TAG_W, 8: width of the opaque tag carried alongside each immediate (e.g. ROB index or PC slice).

Ports:
- Clk  input  1: rising-edge clock.
- Reset  input  1: synchronous, active-high reset.
- InValid  input  1: upstream has a request this cycle.
- InReady  output  1: block accepts a request this cycle.
- Imm26  input  26: instruction bits [25:0].
- Ctrl  input  3: format select (see Behaviour).
- OldVal  input  DATA_W: current destination register value; used only for MOVK.
- InTag  input  TAG_W: tag for this request.
- OutValid  output  1: BusImm, OutTag and Illegal are valid.
- OutReady  input  1: downstream consumes the result this cycle.
- BusImm  output  DATA_W: extended immediate.
- OutTag  output  TAG_W: tag of the result.
- Illegal  output  1: request was an unsupported format or shift.

Behaviour:
- Ctrl decode; all shifts and extensions are performed at width DATA_W:
  - 000 I-type: zero-extend Imm26[21:10].
  - 001 D-type: sign-extend Imm26[20:12].
  - 010 B: sign-extend {Imm26[25:0], 2'b00}.
  - 011 CBZ: sign-extend {Imm26[23:5], 2'b00}.
  - 100 MOVZ: Imm26[20:5] zero-extended, shifted left by 16*hw, where hw = Imm26[22:21].
  - 101 MOVK: see Optional Feature.
  - 110 MOVN: bitwise NOT of the MOVZ result.
  - 111: Illegal=1, BusImm=0.
- Shift legality: for MOVZ, MOVN and MOVK with DATA_W=32 and hw[1]=1, Illegal=1 and BusImm=0.
- Stage 1 (S1): on accept (InValid && InReady), register Imm26, Ctrl, OldVal and InTag; set s1_valid.
- Stage 2 (S2): register the decoded result, Illegal and tag. Outputs are driven directly from S2 flops; there is no combinational path from Imm26 to BusImm.
- Latency is exactly 2 cycles from accept to OutValid when not stalled. Throughput is 1 request per cycle.
- Advance rules:
  - s2_adv = !OutValid || OutReady.
  - s1_adv = s1_valid && s2_adv.
  - InReady = !s1_valid || s2_adv. This is combinational from OutReady; there is no skid buffer.
- Holding rules:
  - While OutValid && !OutReady, BusImm, OutTag and Illegal hold stable.
  - S1 holds its contents while stalled.
- Simultaneous events: accepting into S1 while S1 moves to S2, and S2 handing off while S2 reloads, both occur in the same cycle with no bubble.
- OutValid deasserts only after a handshake with no new S1 data moving up.
- Reset (including mid-stream) clears s1_valid and OutValid to 0, and clears BusImm, OutTag and Illegal to 0. In-flight requests are dropped, not replayed. InReady=1 in the cycle after Reset is released.
- An Illegal result still flows through the pipeline and completes its handshake; it never stalls the pipe.

Optional Feature:
- Macro: IMM_EXTEND_MOVK_EN.
- When defined, Ctrl=101 performs MOVK: registered OldVal with the 16-bit lane at bits [16*hw+15:16*hw] replaced by Imm26[20:5]. The same shift legality rule as MOVZ applies.
- When undefined, Ctrl=101 yields Illegal=1 and BusImm=0. The OldVal port remains present but is ignored, and no OldVal flops are synthesised.

Test Plan:
- I-type, DATA_W=64, Imm26[21:10]=0xFFF, OutReady=1 -> 2 cycles later BusImm=0x0000000000000FFF, Illegal=0, OutTag equals InTag.
- D-type Imm26[20:12]=0x1FF -> BusImm=0xFFFFFFFFFFFFFFFF. B-type Imm26=0x3FFFFFF -> 0xFFFFFFFFFFFFFFFC. CBZ Imm26[23:5]=0x00001 -> 0x0000000000000004.
- MOVZ hw=3, imm=0x1234 -> 0x1234000000000000. MOVN hw=0, imm=0x0001 -> 0xFFFFFFFFFFFFFFFE. DATA_W=32, MOVZ hw=2 -> Illegal=1, BusImm=0.
- IMM_EXTEND_MOVK_EN defined, MOVK hw=1, imm=0x1234, OldVal=0xAAAABBBBCCCCDDDD -> 0xAAAABBBB1234DDDD. Macro undefined, same stimulus -> Illegal=1, BusImm=0.
- Back-to-back stream of 4 requests with tags 1..4, OutReady held low for 3 cycles after the first OutValid:
  - InReady drops once both stages are full.
  - Outputs stay stable during the stall.
  - Results emerge in order 1..4 with no loss or duplication.
  - Throughput returns to 1 per cycle after OutReady rises.
- Assert Reset for 1 cycle with both stages full -> next cycle OutValid=0, BusImm=0, InReady=1. A new request issued immediately completes 2 cycles later.
